// File: rtl/issue_scoreboard_pkg.sv
// Shared constants, lane request type and source-ready rule for the issue scoreboard.
// Build option: SCOREBOARD_FORWARD_EN lets a source be read in the cycle before
// writeback, relying on the datapath bypass network.
package scoreboard_pkg;

  localparam int SB_NUM_LANES = 2;
  localparam int SB_NUM_REGS  = 32;
  localparam int SB_LAT_W     = 3;
  localparam int SB_STALL_W   = 32;

  // Field widths of the lane request; wide enough for any legal parameter set
  localparam int SB_REG_MAX_W = 8;
  localparam int SB_LAT_MAX_W = 8;

  typedef struct packed {
    logic [SB_REG_MAX_W-1:0] rs1;
    logic [SB_REG_MAX_W-1:0] rs2;
    logic [SB_REG_MAX_W-1:0] rd;
    logic                    we;
    logic [SB_LAT_MAX_W-1:0] lat;
  } lane_req_t;

  // A source operand may be read once its producer's countdown allows it
  function automatic logic src_ready(input logic [SB_LAT_MAX_W-1:0] cnt);
`ifdef SCOREBOARD_FORWARD_EN
    return (cnt <= SB_LAT_MAX_W'(1));
`else
    return (cnt == '0);
`endif
  endfunction

endpackage

// File: rtl/issue_scoreboard_reg_timer.sv
// Countdown for one architectural register: flush beats set, set beats decrement.
module scoreboard_reg_timer
  import scoreboard_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_set,
  input  logic [LAT_W-1:0] i_set_val,
  output logic [LAT_W-1:0] o_count
);

  logic [LAT_W-1:0] r_count;

  // Remaining cycles until the pending write to this register is readable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_set) begin
      r_count <= i_set_val;
    end else if (r_count != '0) begin
      r_count <= r_count - LAT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-lane issue/hazard unit. Lane 0 is oldest; the first blocked
// valid lane freezes itself and every valid lane above it.
// Build option: SCOREBOARD_FORWARD_EN (source readiness, see scoreboard_pkg).
module issue_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int  NUM_LANES = SB_NUM_LANES,
  parameter int  NUM_REGS  = SB_NUM_REGS,
  parameter int  LAT_W     = SB_LAT_W,
  parameter int  STALL_W   = SB_STALL_W,
  localparam int REG_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES*REG_W-1:0] lane_rs1,
  input  logic [NUM_LANES*REG_W-1:0] lane_rs2,
  input  logic [NUM_LANES*REG_W-1:0] lane_rd,
  input  logic [NUM_LANES-1:0]       lane_we,
  input  logic [NUM_LANES*LAT_W-1:0] lane_lat,
  output logic [NUM_LANES-1:0]       lane_issue,
  output logic [NUM_LANES-1:0]       lane_freeze,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic [STALL_W-1:0]         stall_cycles
);

  lane_req_t            w_req [NUM_LANES];
  logic [LAT_W-1:0]     w_cnt [NUM_REGS];
  logic [NUM_LANES-1:0] w_ok;
  logic [NUM_LANES-1:0] w_issue;
  logic [NUM_REGS-1:1]  w_set_en;
  logic [LAT_W-1:0]     w_set_val [1:NUM_REGS-1];
  logic [STALL_W-1:0]   r_stall;

  // x0 never has a pending write
  assign w_cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    scoreboard_reg_timer #(.LAT_W(LAT_W)) u_timer (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_flush   (flush),
      .i_set     (w_set_en[r]),
      .i_set_val (w_set_val[r]),
      .o_count   (w_cnt[r])
    );
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic w_src_ok;
    logic w_dst_ok;
    logic w_pair_ok;
    logic w_prior_ok;

    assign w_req[i] = '{rs1: SB_REG_MAX_W'(lane_rs1[i*REG_W +: REG_W]),
                        rs2: SB_REG_MAX_W'(lane_rs2[i*REG_W +: REG_W]),
                        rd:  SB_REG_MAX_W'(lane_rd[i*REG_W +: REG_W]),
                        we:  lane_we[i],
                        lat: SB_LAT_MAX_W'(lane_lat[i*LAT_W +: LAT_W])};

    // Hazards against in-flight writes: RAW on both sources, WAW on rd
    always_comb begin
      w_src_ok = (w_req[i].rs1 == '0 ||
                  src_ready(SB_LAT_MAX_W'(w_cnt[REG_W'(w_req[i].rs1)]))) &&
                 (w_req[i].rs2 == '0 ||
                  src_ready(SB_LAT_MAX_W'(w_cnt[REG_W'(w_req[i].rs2)])));
      w_dst_ok = !w_req[i].we || w_req[i].rd == '0 ||
                 w_cnt[REG_W'(w_req[i].rd)] == '0;
    end

    // Intra-bundle RAW/WAW against older valid lanes; if any older valid lane
    // fails to issue this lane is blocked anyway, so validity stands in for issue
    always_comb begin
      w_pair_ok = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (lane_valid[j] && w_req[j].we && w_req[j].rd != '0 &&
            (w_req[j].rd == w_req[i].rs1 || w_req[j].rd == w_req[i].rs2 ||
             (w_req[i].we && w_req[j].rd == w_req[i].rd))) begin
          w_pair_ok = 1'b0;
        end
      end
    end

    assign w_ok[i] = lane_valid[i] && !flush && w_src_ok && w_dst_ok && w_pair_ok;

    // Strict in-order: every older valid lane must itself be clear to issue
    always_comb begin
      w_prior_ok = 1'b1;
      for (int j = 0; j < i; j++) begin
        if (lane_valid[j] && !w_ok[j]) begin
          w_prior_ok = 1'b0;
        end
      end
    end

    assign w_issue[i] = w_ok[i] && w_prior_ok;
  end

  // Load countdowns for issuing writers; at most one writer per register
  always_comb begin
    w_set_en = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_set_val[r] = '0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_issue[i] && w_req[i].we && w_req[i].rd != '0 && w_req[i].lat != '0) begin
        w_set_en[REG_W'(w_req[i].rd)]  = 1'b1;
        w_set_val[REG_W'(w_req[i].rd)] = LAT_W'(w_req[i].lat);
      end
    end
  end

  // Busy flags straight from the countdown registers
  always_comb begin
    busy_vec[0] = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_vec[r] = (w_cnt[r] != '0);
    end
  end

  // Saturating count of cycles in which some valid lane was held back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
    end else if (!flush && (|lane_freeze) && r_stall != '1) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign lane_issue   = w_issue;
  assign lane_freeze  = lane_valid & ~w_issue;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: 4 lanes, 32 registers, 4-bit stall counter.
module tb_issue_scoreboard;

  localparam int NL  = 4;
  localparam int NR  = 32;
  localparam int RW  = 5;
  localparam int LW  = 3;
  localparam int SW  = 4;
  localparam int SMAX = 15;
`ifdef SCOREBOARD_FORWARD_EN
  localparam int RAW_WAIT = 3;
`else
  localparam int RAW_WAIT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NL-1:0]    valid, we;
  logic [NL*RW-1:0] rs1, rs2, rd;
  logic [NL*LW-1:0] lat;
  logic [NL-1:0]    issue, freeze;
  logic [NR-1:0]    busy_vec;
  logic [SW-1:0]    stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int busy_n;

  issue_scoreboard #(.NUM_LANES(NL), .NUM_REGS(NR), .LAT_W(LW), .STALL_W(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .lane_valid   (valid),
    .lane_rs1     (rs1),
    .lane_rs2     (rs2),
    .lane_rd      (rd),
    .lane_we      (we),
    .lane_lat     (lat),
    .lane_issue   (issue),
    .lane_freeze  (freeze),
    .busy_vec     (busy_vec),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setl(input int i, input bit v, input int a, input int b,
                      input int d, input bit w, input int l);
    valid[i]         = v;
    rs1[i*RW +: RW]  = RW'(a);
    rs2[i*RW +: RW]  = RW'(b);
    rd[i*RW +: RW]   = RW'(d);
    we[i]            = w;
    lat[i*LW +: LW]  = LW'(l);
  endtask

  task automatic clr();
    valid = '0; we = '0; rs1 = '0; rs2 = '0; rd = '0; lat = '0;
  endtask

  // One clock edge; st says whether the bench expects a counted stall in the cycle ending here
  task automatic tick(input bit st);
    @(posedge clk);
    if (st && exp_stall < SMAX) exp_stall++;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_issue", issue, 0);
    chk("rst_freeze", freeze, 0);
    rst = 1'b0;
    #1;

    // Independent pair
    setl(0, 1, 10, 11, 1, 1, 1);
    setl(1, 1, 3, 4, 2, 1, 2);
    #1;
    chk("pair_issue", issue, 4'b0011);
    chk("pair_freeze", freeze, 4'b0000);
    tick(0); clr(); #1;
    chk("pair_busy", busy_vec, 32'h6);
    tick(0);
    chk("pair_busy2", busy_vec, 32'h4);
    tick(0);
    chk("pair_busy3", busy_vec, 0);
    chk("pair_stall", stall_cycles, 0);

    // Intra-bundle RAW, then lane 1 alone (lane 0 invalid) until x5 is readable
    setl(0, 1, 0, 0, 5, 1, 3);
    setl(1, 1, 5, 0, 6, 1, 1);
    #1;
    chk("raw_issue", issue, 4'b0001);
    chk("raw_freeze", freeze, 4'b0010);
    tick(1);
    chk("raw_stall", stall_cycles, exp_stall);
    chk("raw_busy5", busy_vec[5], 1);
    setl(0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 1; k < RAW_WAIT; k++) begin
      chk("raw_wait_issue", issue, 0);
      tick(1);
    end
    chk("raw_release_issue", issue, 4'b0010);
    chk("raw_wait_stall", stall_cycles, exp_stall);
    tick(0); clr();
    tick(0);
    chk("raw_drain_busy", busy_vec, 0);

    // In-order blocking behind busy x7; lane 0 has we=0 and a busy rd that must be ignored
    setl(0, 1, 0, 0, 7, 1, 4);
    #1;
    chk("ord_setup_issue", issue, 4'b0001);
    tick(0); clr();
    setl(0, 1, 1, 2, 7, 0, 0);
    setl(1, 1, 7, 0, 8, 1, 1);
    setl(2, 1, 3, 4, 10, 1, 1);
    setl(3, 1, 0, 0, 11, 1, 1);
    #1;
    chk("ord_issue", issue, 4'b0001);
    chk("ord_freeze", freeze, 4'b1110);
    tick(1); clr();
    repeat (3) tick(0);
    chk("ord_drain_busy", busy_vec, 0);
    chk("ord_stall", stall_cycles, exp_stall);

    // Writes to x0 never mark it busy; reading x0 is always ready
    setl(0, 1, 0, 0, 0, 1, 5);
    setl(1, 1, 0, 0, 3, 1, 0);
    #1;
    chk("x0_issue", issue, 4'b0011);
    chk("x0_freeze", freeze, 4'b0000);
    tick(0); clr(); #1;
    chk("x0_busy", busy_vec, 0);

    // WAW on x9 while its countdown is 2
    setl(0, 1, 0, 0, 9, 1, 3);
    #1;
    chk("waw_first_issue", issue, 4'b0001);
    tick(0); clr();
    tick(0);
    setl(0, 1, 0, 0, 9, 1, 1);
    #1;
    chk("waw_freeze_c2", freeze, 4'b0001);
    chk("waw_busy9_c2", busy_vec[9], 1);
    tick(1);
    chk("waw_freeze_c1", freeze, 4'b0001);
    chk("waw_busy9_c1", busy_vec[9], 1);
    tick(1);
    chk("waw_busy9_clear", busy_vec[9], 0);
    chk("waw_issue", issue, 4'b0001);
    tick(0); clr();
    tick(0);
    chk("waw_drain_busy", busy_vec, 0);

    // Maximum latency gives exactly seven busy cycles
    setl(0, 1, 0, 0, 12, 1, 7);
    #1;
    tick(0); clr();
    busy_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy_vec[12]) busy_n++;
      tick(0);
    end
    chk("lat7_busy_cycles", busy_n, 7);

    // Every cycle stalls: lane 1 RAW-blocked by lane 0, lane 0 WAW-blocked by its own earlier write
    setl(0, 1, 0, 0, 13, 1, 7);
    setl(1, 1, 13, 0, 14, 1, 1);
    #1;
    chk("sat_first_issue", issue, 4'b0001);
    for (int k = 0; k < 20; k++) tick(1);
    chk("sat_stall", stall_cycles, exp_stall);
    chk("sat_stall_ones", stall_cycles, SMAX);

    // Flush while saturated: no issue, counter stays all-ones, countdowns cleared
    flush = 1'b1;
    #1;
    chk("sflush_issue", issue, 0);
    chk("sflush_freeze", freeze, 4'b0011);
    tick(0);
    flush = 1'b0; clr(); #1;
    chk("sflush_stall", stall_cycles, SMAX);
    chk("sflush_busy", busy_vec, 0);

    // Asynchronous reset between edges with a pending write
    setl(0, 1, 0, 0, 13, 1, 7);
    #1;
    tick(0); clr(); #1;
    chk("pre_rst_busy13", busy_vec[13], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy_vec, 0);
    chk("arst_stall", stall_cycles, 0);
    exp_stall = 0;
    #1;
    rst = 1'b0;
    tick(0);

    // Flush with x4 countdown at 5
    setl(0, 1, 0, 0, 4, 1, 5);
    setl(1, 1, 4, 0, 6, 1, 1);
    #1;
    chk("fl_setup_issue", issue, 4'b0001);
    tick(1);
    chk("fl_stall_before", stall_cycles, exp_stall);
    chk("fl_busy4", busy_vec[4], 1);
    flush = 1'b1;
    setl(0, 1, 1, 2, 3, 1, 1);
    #1;
    chk("fl_issue", issue, 0);
    tick(0);
    flush = 1'b0; clr(); #1;
    chk("fl_busy", busy_vec, 0);
    chk("fl_stall_after", stall_cycles, exp_stall);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
